ws2812b_pixel_streamer: RTL and testbench

Parametrised WS2812B-class line driver that accepts whole pixel words over a valid/ready stream and serialises them MSB-first as NRZ codes on a single data output. It generalises the single-bit NRZ code generator: configurable pixel width (RGB/RGBW), bit timing and latch period, with back-to-back pixel streaming, underrun detection and automatic frame latch. It sits between the frame/pixel source logic and the LED strip pin.

---
 rtl/ws2812b_pixel_streamer.sv | 142 ++++++++++++++
 tb/tb_ws2812b_pixel_streamer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_pixel_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ws2812b_pixel_streamer
// Function : Serialises valid/ready pixel words MSB-first as WS2812B NRZ codes,
//            with seamless back-to-back pixels, underrun flag and frame latch.
// Revision : 1.0  initial release
// ============================================================================
module ws2812b_pixel_streamer #(
    parameter int PIXEL_BITS      = 24,
    parameter int BIT_PERIOD_CLKS = 62,
    parameter int T0H_CLKS        = 19,
    parameter int T1H_CLKS        = 39,
    parameter int RESET_CLKS      = 2600
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIXEL_BITS-1:0] pixel_data,
    input  logic                  pixel_last,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic                  dout,
    output logic                  busy,
    output logic                  underrun,
    output logic                  frame_done
);

    localparam int CNT_MAX = (BIT_PERIOD_CLKS > RESET_CLKS) ? BIT_PERIOD_CLKS : RESET_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;

    localparam logic [CNT_W-1:0] c_BIT_LAST = CNT_W'(BIT_PERIOD_CLKS - 1);
    localparam logic [CNT_W-1:0] c_RST_LAST = CNT_W'(RESET_CLKS - 1);
    localparam logic [CNT_W-1:0] c_T0H      = CNT_W'(T0H_CLKS);
    localparam logic [CNT_W-1:0] c_T1H      = CNT_W'(T1H_CLKS);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(PIXEL_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                state_q;
    logic [PIXEL_BITS-1:0] sr_q;
    logic                  last_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  dout_q;
    logic                  busy_q;
    logic                  underrun_q;
    logic                  frame_done_q;

    logic w_bit_end;
    logic w_pix_end;
    logic w_xfer;

    assign w_bit_end = (cnt_q == c_BIT_LAST);
    assign w_pix_end = (state_q == S_SEND) && w_bit_end && (idx_q == c_IDX_LAST);
    assign w_xfer    = pixel_valid && pixel_ready;

    // Ready depends only on state/counters so a source may wait on it.
    always_comb begin
        pixel_ready = 1'b0;
        case (state_q)
            S_IDLE, S_WAIT: pixel_ready = 1'b1;
            S_SEND:         pixel_ready = w_pix_end && !last_q;
            default:        pixel_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WAIT: begin
                    dout_q <= 1'b0;
                    if (w_xfer) begin
                        sr_q    <= pixel_data;
                        last_q  <= pixel_last;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    dout_q <= (cnt_q < (sr_q[PIXEL_BITS-1] ? c_T1H : c_T0H));
                    if (w_bit_end) begin
                        cnt_q <= '0;
                        sr_q  <= sr_q << 1;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == c_IDX_LAST) begin
                            idx_q <= '0;
                            if (w_xfer) begin
                                sr_q   <= pixel_data;
                                last_q <= pixel_last;
                            end else if (last_q) begin
                                state_q <= S_LATCH;
                            end else begin
                                underrun_q <= 1'b1;
                                state_q    <= S_WAIT;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    dout_q <= 1'b0;
                    if (cnt_q == c_RST_LAST) begin
                        cnt_q        <= '0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_pixel_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ws2812b_pixel_streamer
// Function : Directed bench for the WS2812B pixel streamer (small and default
//            parameter sets) against a timeline model of the line waveform.
// Revision : 1.0  initial release
// ============================================================================
module tb_ws2812b_pixel_streamer;

    localparam int PB = 8;
    localparam int BP = 10;
    localparam int T0 = 3;
    localparam int T1 = 7;
    localparam int RC = 20;

    typedef int runs8_t [8];

    runs8_t RUN_A5 = '{7, 3, 7, 3, 3, 7, 3, 7};
    runs8_t RUN_81 = '{7, 3, 3, 3, 3, 3, 3, 7};
    runs8_t RUN_0F = '{3, 3, 3, 3, 7, 7, 7, 7};
    runs8_t RUN_F0 = '{7, 7, 7, 7, 3, 3, 3, 3};
    runs8_t RUN_01 = '{3, 3, 3, 3, 3, 3, 3, 7};
    runs8_t RUN_3C = '{3, 3, 7, 7, 7, 7, 3, 3};

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  a_data  = '0;
    logic        a_last  = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready, a_dout, a_busy, a_ur, a_fd;
    logic [23:0] b_data  = '0;
    logic        b_last  = 1'b0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_dout, b_busy, b_ur, b_fd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    bit ad[$], ab[$], ar[$], au[$], af[$], bd[$], bb[$], bf[$], bu[$];

    always #5 clk = ~clk;

    ws2812b_pixel_streamer #(
        .PIXEL_BITS(PB), .BIT_PERIOD_CLKS(BP), .T0H_CLKS(T0), .T1H_CLKS(T1), .RESET_CLKS(RC)
    ) u_dut_a (
        .clk(clk), .reset(reset), .pixel_data(a_data), .pixel_last(a_last),
        .pixel_valid(a_valid), .pixel_ready(a_ready), .dout(a_dout), .busy(a_busy),
        .underrun(a_ur), .frame_done(a_fd)
    );

    ws2812b_pixel_streamer u_dut_b (
        .clk(clk), .reset(reset), .pixel_data(b_data), .pixel_last(b_last),
        .pixel_valid(b_valid), .pixel_ready(b_ready), .dout(b_dout), .busy(b_busy),
        .underrun(b_ur), .frame_done(b_fd)
    );

    // Timeline model: phase 0 idle, 1 pixel in flight, 2 starved, 3 latch gap.
    int       m_phase = 0;
    int       m_acc   = 0;
    int       m_latch = 0;
    logic [7:0] m_pix = '0;
    bit       m_last  = 1'b0;
    bit e_dout = 1'b0, e_busy = 1'b0, e_ready = 1'b1, e_ur = 1'b0, e_fd = 1'b0;

    always @(posedge clk) begin : model
        int k;
        bit b;
        bit xfer;
        cyc    = cyc + 1;
        xfer   = a_valid && e_ready;
        e_ur   = 1'b0;
        e_fd   = 1'b0;
        e_dout = 1'b0;
        if (m_phase == 1 && cyc > m_acc && cyc <= m_acc + PB*BP) begin
            k      = cyc - m_acc - 1;
            b      = m_pix[PB-1 - k/BP];
            e_dout = ((k % BP) < (b ? T1 : T0));
        end
        if (reset) begin
            m_phase = 0;
            e_dout  = 1'b0;
        end else if (m_phase == 1 && cyc == m_acc + PB*BP) begin
            if (xfer) begin
                m_acc = cyc; m_pix = a_data; m_last = a_last;
            end else if (m_last) begin
                m_phase = 3; m_latch = cyc;
            end else begin
                m_phase = 2; e_ur = 1'b1;
            end
        end else if (m_phase == 3 && cyc == m_latch + RC) begin
            m_phase = 0; e_fd = 1'b1;
        end else if ((m_phase == 0 || m_phase == 2) && xfer) begin
            m_phase = 1; m_acc = cyc; m_pix = a_data; m_last = a_last;
        end
        e_busy  = (m_phase != 0);
        e_ready = (m_phase == 0 || m_phase == 2) ||
                  (m_phase == 1 && !m_last && cyc == m_acc + PB*BP - 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({a_dout, a_busy, a_ready, a_ur, a_fd} !== {e_dout, e_busy, e_ready, e_ur, e_fd}) begin
                errors++;
                $display("FAIL model-compare cyc=%0d dout/busy/ready/underrun/frame_done got %b expected %b",
                         cyc, {a_dout, a_busy, a_ready, a_ur, a_fd}, {e_dout, e_busy, e_ready, e_ur, e_fd});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [23:0] d, input bit l, input bit hold, output int t);
        t = -1;
        if (sel) begin b_data = d; b_last = l; b_valid = 1'b1; end
        else begin a_data = d[7:0]; a_last = l; a_valid = 1'b1; end
        for (int i = 0; i < 400 && t < 0; i++) begin
            @(negedge clk);
            if ((sel ? b_ready : a_ready) === 1'b1) begin
                @(posedge clk); #1;
                t = cyc;
            end
        end
        #1;
        if (!hold) begin a_valid = 1'b0; b_valid = 1'b0; end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL push-timeout: got no transfer expected one within 400 cycles");
        end
    endtask

    // Sample j holds the outputs in the cycle after edge (start + j).
    task automatic record(input int n);
        ad.delete(); ab.delete(); ar.delete(); au.delete(); af.delete();
        bd.delete(); bb.delete(); bf.delete(); bu.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ad.push_back(a_dout); ab.push_back(a_busy); ar.push_back(a_ready);
            au.push_back(a_ur);   af.push_back(a_fd);
            bd.push_back(b_dout); bb.push_back(b_busy); bf.push_back(b_fd); bu.push_back(b_ur);
        end
        tick();
    endtask

    function automatic int hi_cnt(input int q, input int lo, input int hi);
        int c = 0;
        for (int j = lo; j <= hi; j++) begin
            case (q)
                0: c += int'(ad[j]);
                1: c += int'(ab[j]);
                2: c += int'(ar[j]);
                3: c += int'(au[j]);
                4: c += int'(af[j]);
                5: c += int'(bd[j]);
                6: c += int'(bb[j]);
                7: c += int'(bf[j]);
                default: c += int'(bu[j]);
            endcase
        end
        return c;
    endfunction

    task automatic chk_slots(input string name, input runs8_t exp);
        for (int s = 0; s < 8; s++)
            chk($sformatf("%s slot%0d high", name, s), hi_cnt(0, 1 + BP*s, BP + BP*s), exp[s]);
    endtask

    initial begin : stim
        int t, t1, t2, bad;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("reset dout", a_dout, 0);
        chk("reset busy", a_busy, 0);
        chk("reset ready", a_ready, 1);
        chk("reset underrun", a_ur, 0);
        chk("reset frame_done", a_fd, 0);
        chk("reset b busy", b_busy, 0);
        @(posedge clk); #2;
        reset = 1'b0;

        // Single pixel, full frame
        push(1'b0, 24'hA5, 1'b1, 1'b0, t);
        record(110);
        chk_slots("A5", RUN_A5);
        chk("A5 latch highs", hi_cnt(0, 81, 100), 0);
        chk("A5 busy cycles", hi_cnt(1, 0, 109), 100);
        chk("A5 frame_done at 100", int'(af[100]), 1);
        chk("A5 frame_done count", hi_cnt(4, 0, 109), 1);

        // Back-to-back stream
        push(1'b0, 24'hFF, 1'b0, 1'b1, t);
        push(1'b0, 24'h00, 1'b0, 1'b1, t1);
        push(1'b0, 24'h81, 1'b1, 1'b0, t2);
        chk("stream 2nd transfer offset", t1 - t, 80);
        chk("stream 3rd transfer offset", t2 - t, 160);
        record(110);
        chk_slots("81", RUN_81);
        chk("stream frame_done at 100", int'(af[100]), 1);
        chk("stream underrun count", hi_cnt(3, 0, 109), 0);

        // Starved source
        push(1'b0, 24'h0F, 1'b0, 1'b0, t);
        record(95);
        chk_slots("0F", RUN_0F);
        chk("underrun at 80", int'(au[80]), 1);
        chk("underrun count", hi_cnt(3, 0, 94), 1);
        chk("gap highs", hi_cnt(0, 81, 94), 0);
        push(1'b0, 24'hF0, 1'b1, 1'b0, t2);
        chk("resume transfer offset", t2 - t, 96);
        record(110);
        chk_slots("F0", RUN_F0);
        chk("resume frame_done at 100", int'(af[100]), 1);

        // Reset mid-frame
        push(1'b0, 24'hFF, 1'b1, 1'b0, t);
        record(35);
        chk("pre-abort busy", int'(ab[34]), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        record(30);
        chk("abort dout", int'(ad[0]), 0);
        chk("abort busy", int'(ab[0]), 0);
        chk("abort ready", int'(ar[0]), 1);
        chk("abort frame_done count", hi_cnt(4, 0, 29), 0);
        push(1'b0, 24'h01, 1'b1, 1'b0, t);
        record(110);
        chk_slots("01", RUN_01);
        chk("post-abort frame_done at 100", int'(af[100]), 1);

        // Valid held through the latch gap
        push(1'b0, 24'h5A, 1'b1, 1'b0, t);
        push(1'b0, 24'h3C, 1'b1, 1'b0, t2);
        chk("post-latch transfer offset", t2 - t, 101);
        record(110);
        chk_slots("3C", RUN_3C);
        chk("3C frame_done at 100", int'(af[100]), 1);
        tick(); tick();

        // Default timing, 24-bit pixel
        push(1'b1, 24'h800001, 1'b1, 1'b0, t);
        record(4100);
        chk("def bit0 high", hi_cnt(5, 1, 62), 39);
        bad = 0;
        for (int s = 1; s < 23; s++)
            if (hi_cnt(5, 1 + 62*s, 62 + 62*s) != 19) bad++;
        chk("def middle slots wrong", bad, 0);
        chk("def bit23 high", hi_cnt(5, 1 + 62*23, 62*24), 39);
        chk("def latch highs", hi_cnt(5, 1489, 4088), 0);
        chk("def busy cycles", hi_cnt(6, 0, 4099), 4088);
        chk("def frame_done at 4088", int'(bf[4088]), 1);
        chk("def underrun count", hi_cnt(8, 0, 4099), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
